// File: rtl/phasegen.sv
// phasegen: instruction phase sequencer (IDLE -> IF -> DE -> EX -> WB) with HALT on
// illegal opcode or ECALL. Optional performance counters are built when the macro
// PHASEGEN_PERF_EN is defined; otherwise `cycles` and `instret` read as zero.
module phasegen (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [3:0]  cstate,
  output logic        halted,
  output logic        illegal,
  output logic        retire,
  output logic [31:0] cycles,
  output logic [31:0] instret
);

  // Major opcodes recognised by the decoder.
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StIf   = 3'd1,
    StDe   = 3'd2,
    StEx   = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [6:0] opcode;
  logic       opcode_legal;
  logic       opcode_mem;
  logic       opcode_system;
  logic       wb_done;
  logic       active;

  assign opcode = ir[6:0];

  // Only the major opcode field steers sequencing; the rest of IR is ignored here.
  logic unused_ir;
  assign unused_ir = ^ir[31:7];

  // Opcode classification used by DE (legality) and WB (memory wait, ECALL halt).
  always_comb begin
    opcode_legal  = 1'b0;
    opcode_mem    = 1'b0;
    opcode_system = 1'b0;
    case (opcode)
      OpOp, OpOpImm, OpBranch, OpJal, OpJalr, OpLui, OpAuipc: opcode_legal = 1'b1;
      OpLoad, OpStore: begin
        opcode_legal = 1'b1;
        opcode_mem   = 1'b1;
      end
      OpSystem: begin
        opcode_legal  = 1'b1;
        opcode_system = 1'b1;
      end
      default: opcode_legal = 1'b0;
    endcase
  end

  // Loads and stores stall in WB until memory answers; everything else takes one cycle.
  assign wb_done = !(opcode_mem && !mem_ready);

  // Next-state logic; retire is a Mealy pulse on the completing WB cycle.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // step only matters here; run+step together is simply run.
        if (run || step) begin
          state_d = StIf;
        end
      end
      StIf: begin
        if (mem_ready) begin
          state_d = StDe;
        end
      end
      StDe: begin
        if (!opcode_legal) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d = StEx;
        end
      end
      StEx: begin
        state_d = StWb;
      end
      StWb: begin
        if (wb_done) begin
          retire = 1'b1;
          if (opcode_system) begin
            state_d = StHalt;
          end else if (run) begin
            state_d = StIf;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StHalt: begin
        // Only reset leaves HALT.
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and sticky illegal flag; reset wins over everything, including HALT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // One-hot phase decoded purely from the state register.
  always_comb begin
    cstate = 4'b0000;
    unique case (state_q)
      StIf:    cstate = 4'b0001;
      StDe:    cstate = 4'b0010;
      StEx:    cstate = 4'b0100;
      StWb:    cstate = 4'b1000;
      default: cstate = 4'b0000;
    endcase
  end

  assign halted  = (state_q == StHalt);
  assign illegal = illegal_q;
  assign active  = (state_q != StIdle) && (state_q != StHalt);

`ifdef PHASEGEN_PERF_EN
  logic [31:0] cycles_q;
  logic [31:0] instret_q;

  // Free-running wrap-around counters of active cycles and retired instructions.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycles_q  <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      if (active) begin
        cycles_q <= cycles_q + 32'd1;
      end
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign cycles  = cycles_q;
  assign instret = instret_q;
`else
  logic unused_active;
  assign unused_active = active;
  assign cycles        = 32'd0;
  assign instret       = 32'd0;
`endif

  // Structural sanity: at most one phase bit, and no phase while halted.
  a_cstate_onehot0 : assert property (@(posedge clock) disable iff (reset) $onehot0(cstate));
  a_halt_no_phase  : assert property (@(posedge clock) disable iff (reset)
                                      halted |-> (cstate == 4'b0000));

endmodule

// File: tb/tb_phasegen.sv
// Self-checking bench for phasegen: directed scenarios with literal expectations, then
// randomized stimulus compared every cycle against an instruction-level behavioural model.
module tb_phasegen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [31:0] ir = 32'd0;
  logic        mem_ready = 1'b0;
  logic [3:0]  cstate;
  logic        halted;
  logic        illegal;
  logic        retire;
  logic [31:0] cycles;
  logic [31:0] instret;

`ifdef PHASEGEN_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  localparam logic [31:0] IrAddi  = 32'h0010_0093;
  localparam logic [31:0] IrAdd   = 32'h0020_80b3;
  localparam logic [31:0] IrLw    = 32'h0000_2083;
  localparam logic [31:0] IrEcall = 32'h0000_0073;

  phasegen dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .step     (step),
    .ir       (ir),
    .mem_ready(mem_ready),
    .cstate   (cstate),
    .halted   (halted),
    .illegal  (illegal),
    .retire   (retire),
    .cycles   (cycles),
    .instret  (instret)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (instruction level) ----------------
  logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111, 7'b1110011};

  // mode: 0 waiting for work, 1 executing an instruction, 2 stopped for good
  int          m_mode = 0;
  int          m_phase = 0;  // 0..3 = IF, DE, EX, WB within the current instruction
  bit          m_ill = 1'b0;
  logic [31:0] m_cyc = 32'd0;
  logic [31:0] m_ret = 32'd0;
  bit          m_valid = 1'b0;
  bit          m_r;

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 10; i++) begin
      if (legal_ops[i] == op) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_retire();
    bit mem_op;
    mem_op = (ir[6:0] == 7'b0000011) || (ir[6:0] == 7'b0100011);
    return (m_mode == 1) && (m_phase == 3) && !(mem_op && !mem_ready);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_mode  = 0;
      m_phase = 0;
      m_ill   = 1'b0;
      m_cyc   = 32'd0;
      m_ret   = 32'd0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_r = model_retire();
      if (PerfEn) begin
        if (m_mode == 1) m_cyc = m_cyc + 32'd1;
        if (m_r) m_ret = m_ret + 32'd1;
      end
      if (m_mode == 0) begin
        if (run || step) begin
          m_mode  = 1;
          m_phase = 0;
        end
      end else if (m_mode == 1) begin
        if (m_phase == 0) begin
          if (mem_ready) m_phase = 1;
        end else if (m_phase == 1) begin
          if (!is_legal(ir[6:0])) begin
            m_mode = 2;
            m_ill  = 1'b1;
          end else begin
            m_phase = 2;
          end
        end else if (m_phase == 2) begin
          m_phase = 3;
        end else if (m_r) begin
          if (ir[6:0] == 7'b1110011) m_mode = 2;
          else if (run) m_phase = 0;
          else m_mode = 0;
        end
      end
    end
  end

  // Compare process: inputs change just after posedge, so at negedge everything is settled.
  always @(negedge clock) begin
    if (m_valid) begin
      check("cstate", {28'd0, cstate}, (m_mode == 1) ? (32'd1 << m_phase) : 32'd0);
      check("halted", {31'd0, halted}, {31'd0, (m_mode == 2)});
      check("illegal", {31'd0, illegal}, {31'd0, m_ill});
      check("retire", {31'd0, retire}, {31'd0, model_retire()});
      check("cycles", cycles, m_cyc);
      check("instret", instret, m_ret);
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  int mr_tab [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 1};
  int cs_tab [9] = '{1, 1, 1, 1, 2, 4, 8, 8, 8};
  int rt_tab [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
  int sel;

  initial begin
    // Reset state.
    do_reset();
    #1;
    check("rst_cstate", {28'd0, cstate}, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'h0);
    check("rst_illegal", {31'd0, illegal}, 32'h0);
    check("rst_retire", {31'd0, retire}, 32'h0);
    check("rst_cycles", cycles, 32'h0);
    check("rst_instret", instret, 32'h0);

    // Ten back-to-back ADDIs with memory always ready.
    ir = IrAddi;
    mem_ready = 1'b1;
    run = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      #1;
      check("addi_cstate", {28'd0, cstate}, 32'd1 << (i % 4));
      check("addi_retire", {31'd0, retire}, ((i % 4) == 3) ? 32'd1 : 32'd0);
      if (i == 39) run = 1'b0;
      tick();
    end
    #1;
    check("addi_idle", {28'd0, cstate}, 32'h0);
    check("addi_cycles", cycles, PerfEn ? 32'd40 : 32'd0);
    check("addi_instret", instret, PerfEn ? 32'd10 : 32'd0);

    // Load with IF wait states and WB wait states: 9 cycles total.
    do_reset();
    ir = IrLw;
    mem_ready = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mem_ready = (mr_tab[i] != 0);
      #1;
      check("lw_cstate", {28'd0, cstate}, cs_tab[i]);
      check("lw_retire", {31'd0, retire}, rt_tab[i]);
      tick();
    end
    #1;
    check("lw_idle", {28'd0, cstate}, 32'h0);

    // Single step of ADD; a step during EX must not start another instruction.
    do_reset();
    ir = IrAdd;
    mem_ready = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    step = 1'b1;
    #1;
    check("step_ex", {28'd0, cstate}, 32'h4);
    tick();
    step = 1'b0;
    #1;
    check("step_wb", {28'd0, cstate}, 32'h8);
    check("step_retire", {31'd0, retire}, 32'h1);
    tick();
    #1;
    check("step_idle", {28'd0, cstate}, 32'h0);
    tick();
    #1;
    check("step_still_idle", {28'd0, cstate}, 32'h0);

    // Illegal opcode halts; run/step ignored until reset.
    do_reset();
    ir = 32'h0;
    run = 1'b1;
    tick();
    tick();
    tick();
    #1;
    check("ill_halted", {31'd0, halted}, 32'h1);
    check("ill_flag", {31'd0, illegal}, 32'h1);
    check("ill_cstate", {28'd0, cstate}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step = i[0];
      ir = IrAddi;
      tick();
      #1;
      check("ill_stuck", {31'd0, halted}, 32'h1);
      check("ill_noretire", {31'd0, retire}, 32'h0);
    end
    do_reset();
    #1;
    check("ill_cleared", {31'd0, illegal}, 32'h0);
    check("ill_unhalted", {31'd0, halted}, 32'h0);

    // ECALL retires, then halts without the illegal flag.
    ir = IrEcall;
    mem_ready = 1'b1;
    run = 1'b1;
    tick();
    tick();
    tick();
    tick();
    #1;
    check("ecall_retire", {31'd0, retire}, 32'h1);
    tick();
    #1;
    check("ecall_halted", {31'd0, halted}, 32'h1);
    check("ecall_illegal", {31'd0, illegal}, 32'h0);
    check("ecall_cstate", {28'd0, cstate}, 32'h0);

    // Reset in EX of the second instruction clears counters.
    do_reset();
    ir = IrAddi;
    mem_ready = 1'b1;
    run = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) tick();
    #1;
    check("mid_ex", {28'd0, cstate}, 32'h4);
    check("mid_cycles", cycles, PerfEn ? 32'd6 : 32'd0);
    check("mid_instret", instret, PerfEn ? 32'd1 : 32'd0);
    reset = 1'b1;
    run = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_cstate", {28'd0, cstate}, 32'h0);
    check("mid_rst_cycles", cycles, 32'h0);
    check("mid_rst_instret", instret, 32'h0);
    check("mid_rst_retire", {31'd0, retire}, 32'h0);

    // Randomized stimulus, checked by the compare process every cycle.
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset     = ($urandom_range(0, 63) == 0);
      run       = ($urandom_range(0, 3) != 0);
      step      = ($urandom_range(0, 7) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      sel       = $urandom_range(0, 15);
      if (sel == 0) ir = $urandom();
      else if (sel == 1) ir = IrEcall;
      else ir = {$urandom_range(0, 32'h1ff_ffff), legal_ops[$urandom_range(0, 8)]};
    end
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phasegen.md
PHASEGEN -- requirements
Module: phasegen

Interface
REQ-001 The block SHALL have one clock `clock` and a synchronous, active-high reset `reset`.
REQ-002 `clock`  input  1  rising-edge system clock.
REQ-003 `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clock`.
REQ-004 `run`  input  1  level; while high, instructions execute back to back.
REQ-005 `step`  input  1  single-cycle pulse; starts exactly one instruction from IDLE.
REQ-006 `ir`  input  32  current IR value; valid from DE onward (loaded at the end of IF).
REQ-007 `mem_ready`  input  1  memory access complete this cycle; sampled combinationally.
REQ-008 `cstate`  output  4  one-hot phase: IF=0001, DE=0010, EX=0100, WB=1000; 0000 in IDLE and HALT.
REQ-009 `halted`  output  1  high while in HALT.
REQ-010 `illegal`  output  1  sticky; set when HALT is entered because of an illegal opcode.
REQ-011 `retire`  output  1  one-cycle pulse on the cycle a WB completes.
REQ-012 `cycles`  output  32  count of active cycles.
REQ-013 `instret`  output  32  count of retired instructions.

Function
REQ-014 The state machine SHALL have the states IDLE, IF, DE, EX, WB and HALT, all registered.
REQ-015 IDLE SHALL go to IF when `run`=1 or `step`=1; otherwise it stays in IDLE.
REQ-016 IF SHALL hold while `mem_ready`=0 and go to DE on the first cycle `mem_ready`=1.
REQ-017 DE SHALL go to HALT, setting `illegal`, when `ir[6:0]` is not one of the legal opcodes; otherwise DE SHALL go to EX.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.
REQ-018 EX SHALL go to WB unconditionally after exactly one cycle.
REQ-019 WB SHALL hold while `ir[6:0]` is 0000011 (load) or 0100011 (store) and `mem_ready`=0; for every other opcode WB SHALL complete after one cycle.
REQ-020 On WB completion, `retire`=1 for that cycle only, and the next state SHALL be chosen in this order:
- HALT if `ir[6:0]`=1110011;
- else IF if `run`=1;
- else IDLE.
REQ-021 HALT SHALL be left only by `reset`; `run`, `step` and `mem_ready` SHALL be ignored in HALT.
REQ-022 `step` SHALL be ignored outside IDLE; `step` and `run` high together in IDLE SHALL behave as `run`.
REQ-023 Deasserting `run` mid-instruction SHALL NOT abort it; the instruction completes and the block then enters IDLE.
REQ-024 `cstate` SHALL be driven directly from the state register, with no combinational path from inputs.
REQ-025 Minimum instruction latency SHALL be 4 cycles (IF, DE, EX, WB), plus one cycle per wait cycle in IF or load/store WB.

Reset
REQ-026 On `reset`=1 at a clock edge, the state SHALL become IDLE and `cstate`=0000, `halted`=0, `illegal`=0, `retire`=0, `cycles`=0, `instret`=0.
REQ-027 Reset SHALL take priority over every other input, including reset asserted mid-instruction and reset asserted in HALT.
REQ-028 `retire` SHALL be 0 in the cycle after reset regardless of the prior state.

Configuration
REQ-029 With macro PHASEGEN_PERF_EN defined, the counters SHALL be implemented as follows:
- `cycles` increments on every cycle whose state is not IDLE or HALT;
- `instret` increments on every `retire` pulse;
- both wrap from 0xFFFFFFFF to 0.
REQ-030 With PHASEGEN_PERF_EN undefined, `cycles` and `instret` SHALL remain present as ports but be tied to 0, with no counter registers.

Verification
REQ-031 Reset, then `run`=1, `mem_ready`=1, `ir`=ADDI (opcode 0010011):
- `cstate` sequence 0001,0010,0100,1000 repeating;
- `retire` high once every 4 cycles.
REQ-032 `mem_ready` held 0 for 3 cycles in IF, then `ir`=LW with `mem_ready`=0 for 2 cycles in WB -> IF lasts 4 cycles, WB lasts 3 cycles, `retire` pulses in the last WB cycle, total 9 cycles.
REQ-033 `run`=0, one `step` pulse with ADD -> exactly one IF..WB pass, then IDLE with `cstate`=0000; a second `step` issued during EX is ignored.
REQ-034 `ir[6:0]`=0000000 at DE -> next cycle `halted`=1, `illegal`=1, `cstate`=0000, `retire` never asserted; `run`/`step` have no effect until `reset`.
REQ-035 `ir`=ECALL (opcode 1110011) -> `retire` pulses in WB, then HALT with `illegal`=0.
REQ-036 With PHASEGEN_PERF_EN defined, `reset` asserted in EX of the 2nd instruction -> `cycles`=0, `instret`=0, `cstate`=0000 on the next cycle.
REQ-037 With PHASEGEN_PERF_EN defined, 10 ADDI instructions at `mem_ready`=1 -> `instret`=10, `cycles`=40.
